multi_push_multi_pop_fifo: RTL and testbench

MULTI_PUSH_MULTI_POP_FIFO -- requirements
Module: multi_push_multi_pop_fifo

---
 rtl/multi_push_multi_pop_fifo.sv | 80 ++++++++
 tb/tb_multi_push_multi_pop_fifo.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/multi_push_multi_pop_fifo.sv
// Multi-word FIFO: up to N words pushed and popped per cycle.
// Circular buffer of D entries with show-ahead read lanes.
module multi_push_multi_pop_fifo #(
    parameter int W = 8,
    parameter int D = 4,
    parameter int N = 4,
    localparam int WN = $clog2(N + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WN-1:0]         push,
    input  logic [N-1:0][W-1:0]   push_data,
    input  logic [WN-1:0]         pop,
    output logic [N-1:0][W-1:0]   pop_data,
    output logic [WN-1:0]         can_push,
    output logic [WN-1:0]         can_pop
);

    localparam int CW = $clog2(D + 1);
    localparam int PW = (D > 1) ? $clog2(D) : 1;

    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [W-1:0]  mem [D];

    logic          push_ok;
    logic          pop_ok;
    logic [CW-1:0] push_amt;
    logic [CW-1:0] pop_amt;

    // base + off never reaches 2*D, so one subtraction wraps it
    function automatic logic [PW-1:0] wrap(input logic [PW-1:0] base,
                                           input int off);
        int s;
        s = int'(base) + off;
        if (s >= D) s = s - D;
        return PW'(s);
    endfunction

    // Availability from registered count; oversize requests are dropped
    always_comb begin
        can_pop  = (int'(count) > N) ? WN'(N) : WN'(count);
        can_push = ((D - int'(count)) > N) ? WN'(N)
                                           : WN'(D - int'(count));
        push_ok  = (push != '0) && (push <= can_push);
        pop_ok   = (pop != '0) && (pop <= can_pop);
        push_amt = push_ok ? CW'(push) : '0;
        pop_amt  = pop_ok ? CW'(pop) : '0;
    end

    // Pointer and occupancy state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wrap(wr_ptr, int'(push));
            if (pop_ok)  rd_ptr <= wrap(rd_ptr, int'(pop));
            count <= count + push_amt - pop_amt;
        end
    end

    // Storage write: lanes below push land at consecutive entries
    always_ff @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (push_ok && (i < int'(push)))
                mem[wrap(wr_ptr, i)] <= push_data[i];
        end
    end

    // Show-ahead read lanes, oldest word on lane 0
    always_comb begin
        pop_data = '0;
        for (int i = 0; i < N; i++)
            pop_data[i] = mem[wrap(rd_ptr, i)];
    end

endmodule

// File: tb/tb_multi_push_multi_pop_fifo.sv
// Scoreboard bench for multi_push_multi_pop_fifo.
// Queue-based reference model; monitor compares after each edge.
module tb_multi_push_multi_pop_fifo;

    localparam int W  = 8;
    localparam int D  = 4;
    localparam int N  = 4;
    localparam int WN = $clog2(N + 1);

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic [WN-1:0]       push = '0;
    logic [WN-1:0]       pop = '0;
    logic [N-1:0][W-1:0] push_data = '0;
    logic [N-1:0][W-1:0] pop_data;
    logic [WN-1:0]       can_push;
    logic [WN-1:0]       can_pop;

    typedef struct {
        int                  cp;
        int                  cpo;
        logic [N-1:0][W-1:0] words;
    } exp_t;

    exp_t       exp_q[$];
    logic [W-1:0] model[$];
    int         n_cmp = 0;
    int         n_bad = 0;

    multi_push_multi_pop_fifo #(.W(W), .D(D), .N(N)) dut (
        .clk(clk),
        .rst(rst),
        .push(push),
        .push_data(push_data),
        .pop(pop),
        .pop_data(pop_data),
        .can_push(can_push),
        .can_pop(can_pop)
    );

    always #5 clk = ~clk;

    function automatic int min2(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic logic [N-1:0][W-1:0] mk(input int a, input int b,
                                               input int c, input int d);
        logic [N-1:0][W-1:0] r;
        r[0] = W'(a);
        r[1] = W'(b);
        r[2] = W'(c);
        r[3] = W'(d);
        return r;
    endfunction

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // Drive one cycle of requests and queue the post-edge expectation
    task automatic step(input int pn, input int qn,
                        input logic [N-1:0][W-1:0] d);
        int   sz;
        int   cpu;
        int   cpo;
        exp_t e;
        @(negedge clk);
        push      = WN'(pn);
        pop       = WN'(qn);
        push_data = d;
        sz  = model.size();
        cpu = min2(N, D - sz);
        cpo = min2(N, sz);
        if (qn > 0 && qn <= cpo)
            for (int i = 0; i < qn; i++) void'(model.pop_front());
        if (pn > 0 && pn <= cpu)
            for (int i = 0; i < pn; i++) model.push_back(d[i]);
        sz      = model.size();
        e.cp    = min2(N, D - sz);
        e.cpo   = min2(N, sz);
        e.words = '0;
        for (int i = 0; i < e.cpo; i++) e.words[i] = model[i];
        exp_q.push_back(e);
    endtask

    // Pulse reset between edges and check the effect without a clock
    task automatic reset_pulse();
        @(negedge clk);
        push = '0;
        pop  = '0;
        #2 rst = 1'b0;
        #1;
        check("rst_can_pop", int'(can_pop), 0);
        check("rst_can_push", int'(can_push), min2(N, D));
        #1 rst = 1'b1;
        model.delete();
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("can_push", int'(can_push), e.cp);
                check("can_pop", int'(can_pop), e.cpo);
                for (int i = 0; i < e.cpo; i++)
                    check($sformatf("pop_data[%0d]", i),
                          int'(pop_data[i]), int'(e.words[i]));
            end
        end
    end

    initial begin : driver
        logic [N-1:0][W-1:0] z;
        logic [N-1:0][W-1:0] r;
        z = '0;
        #3;
        check("reset_can_pop", int'(can_pop), 0);
        check("reset_can_push", int'(can_push), min2(N, D));
        @(negedge clk);
        rst = 1'b1;

        step(3, 0, mk(1, 2, 3, 4));
        step(0, 1, z);
        step(0, 1, z);
        step(0, 1, z);
        step(3, 0, mk(6, 7, 8, 9));
        step(0, 3, z);

        step(4, 0, mk(8'hA1, 8'hB2, 8'hC3, 8'hD4));
        step(1, 0, mk(8'hEE, 0, 0, 0));
        step(0, 2, z);
        step(2, 1, mk(8'h50, 8'h51, 0, 0));
        step(0, 1, z);
        step(0, 3, z);
        step(0, 2, z);

        step(3, 0, mk(11, 12, 13, 14));
        reset_pulse();
        step(0, 1, z);
        step(2, 0, mk(21, 22, 0, 0));

        for (int k = 0; k < 400; k++) begin
            if (k % 97 == 50) begin
                reset_pulse();
            end else begin
                for (int i = 0; i < N; i++) r[i] = W'($urandom);
                step(int'($urandom_range(0, N)),
                     int'($urandom_range(0, N)), r);
            end
        end

        @(negedge clk);
        push = '0;
        pop  = '0;
        repeat (3) @(negedge clk);
        check("exp_q_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
